// File: rtl/bcd_operand_entry.sv
// BCD operand entry: shifts key digits into an N-digit operand, hands it off over valid/ready.
// Optional build macro LEADING_ZERO_BLANK_EN blanks unused high-order displays.
module bcd_operand_entry #(
    parameter int DIGITS         = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  key_pulse,
    input  logic [3:0]            key_code,
    input  logic                  op_ready,
    output logic [4*DIGITS-1:0]   operand,
    output logic [3:0]            digit_count,
    output logic                  op_valid,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int         OPW       = 4 * DIGITS;
    localparam logic [3:0] CNT_MAX   = 4'(DIGITS);
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BS    = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    typedef enum logic [1:0] {ST_ENTRY, ST_FULL, ST_COMMIT} state_t;

    state_t           r_state, w_state_nxt;
    logic [OPW-1:0]   r_operand, w_operand_nxt;
    logic [3:0]       r_count, w_count_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [OPW-1:0]   w_shifted;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Written as a shift so the DIGITS = 1 case needs no special slice.
    assign w_shifted = (r_operand << 4) | OPW'(key_code);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= ST_ENTRY;
            r_operand <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_operand <= w_operand_nxt;
            r_count   <= w_count_nxt;
            r_valid   <= w_valid_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_operand_nxt = r_operand;
        w_count_nxt   = r_count;
        w_valid_nxt   = r_valid;
        w_ovf_nxt     = r_ovf;
        case (r_state)
            ST_ENTRY, ST_FULL: begin
                if (key_pulse) begin
                    if (key_code <= 4'd9) begin
                        if (r_state == ST_FULL) begin
                            w_ovf_nxt = 1'b1;
                        end else if (!(r_count == 4'd0 && key_code == 4'd0)) begin
                            w_operand_nxt = w_shifted;
                            w_count_nxt   = r_count + 4'd1;
                            if (r_count + 4'd1 == CNT_MAX)
                                w_state_nxt = ST_FULL;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        w_operand_nxt = '0;
                        w_count_nxt   = '0;
                        w_ovf_nxt     = 1'b0;
                        w_state_nxt   = ST_ENTRY;
                    end else if (key_code == KEY_BS) begin
                        if (r_count != 4'd0) begin
                            w_operand_nxt = r_operand >> 4;
                            w_count_nxt   = r_count - 4'd1;
                            w_ovf_nxt     = 1'b0;
                            w_state_nxt   = ST_ENTRY;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                // Clear aborts a pending transfer; other keys are dropped while committed.
                if ((r_valid && op_ready) || (key_pulse && key_code == KEY_CLEAR)) begin
                    w_valid_nxt   = 1'b0;
                    w_operand_nxt = '0;
                    w_count_nxt   = '0;
                    w_ovf_nxt     = 1'b0;
                    w_state_nxt   = ST_ENTRY;
                end
            end
            default: w_state_nxt = ST_ENTRY;
        endcase
    end

    assign operand     = r_operand;
    assign digit_count = r_count;
    assign op_valid    = r_valid;
    assign overflow    = r_ovf;

    for (genvar i = 0; i < DIGITS; i++) begin : g_disp
        logic       w_blank;
        logic [6:0] w_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 0) begin : g_d0
            assign w_blank = 1'b0;
        end else begin : g_dn
            assign w_blank = (r_count <= 4'(i));
        end
`else
        assign w_blank = 1'b0;
`endif
        assign w_seg = w_blank ? 7'h00 : seg_decode(r_operand[4*i +: 4]);
        assign hex[7*i +: 7] = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
    end

endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
- Parametrised successor to the fixed 3-digit BCD operand store and display path.
- Accepts decoded key pulses from the matrix input manager and builds an N-digit BCD operand by shifting in from the right.
- Supports clear, backspace and enter, plus an overflow flag.
- Hands the finished operand to the downstream calculator datapath over a valid/ready handshake and drives N seven-segment displays directly.

Parameters:
- DIGITS, 3, number of BCD digits held and displayed (1..8).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (DE2 HEX), 0 = active-high.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_pulse  input  1  one-cycle strobe, key_code valid this cycle.
- key_code  input  4  0-9 = digit, 4'hA = clear, 4'hB = backspace, 4'hC = enter, 4'hD-4'hF = ignored.
- op_ready  input  1  downstream accepts operand when high with op_valid.
- operand  output  4*DIGITS  packed BCD, digit 0 (least significant) in [3:0].
- digit_count  output  4  number of digits entered, 0..DIGITS.
- op_valid  output  1  committed operand available.
- overflow  output  1  sticky: a digit was rejected because the entry was full.
- hex  output  7*DIGITS  segments; digit i in [7i+6:7i], bit order g..a.

Behaviour:
- All outputs are registered, except hex, which is combinational from the registered operand and digit_count.
- Reset, or reset mid-operation:
  - operand = 0, digit_count = 0, op_valid = 0, overflow = 0, state = ENTRY.
  - Displays show "0" in digit 0.
  - Reset wins over any same-cycle key_pulse or op_ready.
- Latency: key_pulse sampled at edge t; operand, digit_count and flags reflect it after edge t, so hex changes in the same cycle those registers update.
- States: ENTRY, FULL, COMMIT.
- ENTRY, digit d:
  - operand <= {operand[4*DIGITS-5:0], d}.
  - digit_count += 1.
  - If digit_count reaches DIGITS, go to FULL.
  - Leading zero: digit 0 typed while digit_count = 0 leaves operand = 0 and digit_count = 0.
- FULL, digit: operand unchanged, overflow <= 1, stays FULL.
- ENTRY/FULL, clear: operand = 0, digit_count = 0, overflow = 0, go to ENTRY.
- ENTRY/FULL, backspace:
  - operand <= operand >> 4 (zero fill at the top).
  - digit_count -= 1, saturating at 0.
  - overflow = 0, go to ENTRY.
  - Backspace with digit_count = 0 is a no-op.
- ENTRY/FULL, enter: op_valid <= 1, go to COMMIT. Enter with an empty entry commits operand = 0.
- COMMIT:
  - operand is frozen and keeps being displayed.
  - Handshake completes on the cycle op_valid && op_ready. Next cycle: op_valid = 0, operand = 0, digit_count = 0, overflow = 0, state = ENTRY.
  - op_ready may be held high permanently; the transfer then completes 1 cycle after commit.
  - Key pulses in COMMIT are dropped. Exception: clear aborts the transfer, with op_valid = 0 and operand cleared, and goes to ENTRY.
  - A key_pulse on the same cycle as the handshake is dropped, except clear, which has the same result as the handshake.
- Unknown codes 4'hD-4'hF: no state change in any state.
- Non-BCD operand digits never occur; the display decoder shows blank for codes 10-15 defensively.
- SEG_ACTIVE_LOW = 1 inverts all segment outputs.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined: display digit i is blanked (all segments off) when i >= digit_count and i > 0, so digit 0 always shows a digit. This applies in all states, including COMMIT.
- When undefined: all DIGITS displays always show their BCD value, including leading zeros.
- operand and all other ports are identical in both builds.

Test Plan:
- Reset, then DIGITS = 3, keys 4, 2, 7 -> operand = 12'h427, digit_count = 3, state FULL, hex2/1/0 show 4/2/7, overflow = 0.
- From 427, key 9 -> operand stays 12'h427, overflow = 1. Then backspace -> operand = 12'h042, digit_count = 2, overflow = 0.
- Keys 0, 0, 5 from empty -> operand = 12'h005, digit_count = 1. With LEADING_ZERO_BLANK_EN, hex2 and hex1 are blank and hex0 shows 5; without it, they show 0, 0, 5.
- Keys 1, 2, enter with op_ready = 0 for 4 cycles -> op_valid = 1 and operand = 12'h012 held; key 7 during that time is ignored. Raise op_ready -> op_valid falls next cycle, operand = 0.
- Enter on an empty entry with op_ready = 1 -> one-cycle op_valid with operand = 0. Clear during COMMIT with op_ready = 0 -> op_valid = 0, operand = 0 next cycle.
- Assert reset in the same cycle as a key_pulse of 5 while in FULL with overflow = 1 -> all outputs are at reset values the next cycle. Repeat with DIGITS = 8 and 8 digit keys -> FULL after the 8th key.
